// File: rtl/mipi_csi_packet_parser_if.sv
// Lane-aligned word input and payload/sync output bundle of the CSI-2 packet parser.
// The slave modport is the parser's view; master is the view of whoever drives it.
interface mipi_csi_packet_parser_if;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        output_valid_o;
  logic [31:0] data_o;
  logic [3:0]  byte_en_o;
  logic [2:0]  packet_type_o;
  logic [15:0] packet_length_o;
  logic [1:0]  vc_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        line_end_o;
  logic        ecc_error_o;
  logic        truncated_o;

  modport master (
    output data_valid_i, data_i,
    input  output_valid_o, data_o, byte_en_o, packet_type_o, packet_length_o, vc_o,
    input  frame_start_o, frame_end_o, line_start_o, line_end_o, ecc_error_o, truncated_o
  );

  modport slave (
    input  data_valid_i, data_i,
    output output_valid_o, data_o, byte_en_o, packet_type_o, packet_length_o, vc_o,
    output frame_start_o, frame_end_o, line_start_o, line_end_o, ecc_error_o, truncated_o
  );
endinterface

// File: rtl/mipi_csi_packet_parser.sv
// CSI-2 packet parser: decodes and ECC-checks the header word, pulses frame/line syncs
// for short packets and forwards long-packet payload words (header and CRC stripped).
module mipi_csi_packet_parser #(
  parameter bit         VC_FILTER_EN = 1'b0,
  parameter logic [1:0] VC_SELECT    = 2'd0
) (
  input logic                     clk_i,
  input logic                     reset_i,
  mipi_csi_packet_parser_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPayload, StDrain} state_e;

  state_e      state_q;
  logic [16:0] remaining_q;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic        hdr_ecc_ok;
  logic        hdr_vc_ok;
  logic [2:0]  hdr_type;
  logic [3:0]  last_be;

  // Standard CSI-2 header Hamming parity P0..P5 over DI and WC.
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^
           d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^
           d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^
           d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^
           d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
           d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
           d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  assign hdr_dt     = bus.data_i[5:0];
  assign hdr_vc     = bus.data_i[7:6];
  assign hdr_wc     = bus.data_i[23:8];
  // Top two ECC bits must be zero, so compare the full byte.
  assign hdr_ecc_ok = (bus.data_i[31:24] == {2'b00, calc_ecc(bus.data_i[23:0])});
  assign hdr_vc_ok  = !VC_FILTER_EN || (hdr_vc == VC_SELECT);

  // Map the data type onto the depacker's packet type code.
  always_comb begin
    hdr_type = 3'd0;
    case (hdr_dt)
      6'h2A:   hdr_type = 3'd1;
      6'h2B:   hdr_type = 3'd2;
      6'h2C:   hdr_type = 3'd3;
      6'h2D:   hdr_type = 3'd4;
      6'h1E:   hdr_type = 3'd5;
      default: hdr_type = 3'd0;
    endcase
  end

  // Byte enable for the final payload word; remaining is 1..4 there.
  always_comb begin
    last_be = 4'b1111;
    case (remaining_q[2:0])
      3'd1:    last_be = 4'b0001;
      3'd2:    last_be = 4'b0011;
      3'd3:    last_be = 4'b0111;
      default: last_be = 4'b1111;
    endcase
  end

  // Packet FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q             <= StIdle;
      remaining_q         <= '0;
      bus.output_valid_o  <= 1'b0;
      bus.data_o          <= '0;
      bus.byte_en_o       <= '0;
      bus.packet_type_o   <= '0;
      bus.packet_length_o <= '0;
      bus.vc_o            <= '0;
      bus.frame_start_o   <= 1'b0;
      bus.frame_end_o     <= 1'b0;
      bus.line_start_o    <= 1'b0;
      bus.line_end_o      <= 1'b0;
      bus.ecc_error_o     <= 1'b0;
      bus.truncated_o     <= 1'b0;
    end else begin
      bus.output_valid_o <= 1'b0;
      bus.frame_start_o  <= 1'b0;
      bus.frame_end_o    <= 1'b0;
      bus.line_start_o   <= 1'b0;
      bus.line_end_o     <= 1'b0;
      bus.ecc_error_o    <= 1'b0;
      bus.truncated_o    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.data_valid_i) begin
            if (!hdr_ecc_ok) begin
              bus.ecc_error_o <= 1'b1;
              state_q         <= StDrain;
            end else if (!hdr_vc_ok) begin
              state_q <= StDrain;
            end else if (hdr_dt < 6'h10) begin
              bus.frame_start_o <= (hdr_dt == 6'h00);
              bus.frame_end_o   <= (hdr_dt == 6'h01);
              bus.line_start_o  <= (hdr_dt == 6'h02);
              bus.line_end_o    <= (hdr_dt == 6'h03);
              state_q           <= StDrain;
            end else begin
              bus.packet_length_o <= hdr_wc;
              bus.vc_o            <= hdr_vc;
              bus.packet_type_o   <= hdr_type;
              if (hdr_wc == 16'd0) begin
                state_q <= StDrain;
              end else begin
                remaining_q <= {1'b0, hdr_wc};
                state_q     <= StPayload;
              end
            end
          end
        end
        StPayload: begin
          if (bus.data_valid_i) begin
            bus.data_o         <= bus.data_i;
            bus.output_valid_o <= 1'b1;
            if (remaining_q > 17'd4) begin
              bus.byte_en_o <= 4'b1111;
              remaining_q   <= remaining_q - 17'd4;
            end else begin
              bus.byte_en_o <= last_be;
              remaining_q   <= '0;
              state_q       <= StDrain;
            end
          end else begin
            bus.truncated_o <= 1'b1;
            state_q         <= StIdle;
          end
        end
        StDrain: begin
          // CRC and trailing bytes are dropped until the burst ends.
          if (!bus.data_valid_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_packet_parser.sv
// Bench for mipi_csi_packet_parser: one unfiltered instance and one filtering on VC1,
// both fed the same bursts; output events are scored against per-instance queues.
module tb_mipi_csi_packet_parser;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  mipi_csi_packet_parser_if bus_a ();
  mipi_csi_packet_parser_if bus_f ();

  mipi_csi_packet_parser #(.VC_FILTER_EN(1'b0), .VC_SELECT(2'd0)) dut_a (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus_a)
  );

  mipi_csi_packet_parser #(.VC_FILTER_EN(1'b1), .VC_SELECT(2'd1)) dut_f (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus_f)
  );

  typedef enum logic [2:0] {EvWord, EvFs, EvFe, EvLs, EvLe, EvEcc, EvTrunc} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [31:0] data;
    logic [3:0]  be;
  } ev_t;

  ev_t qa[$];
  ev_t qf[$];
  int  vecs = 0;
  int  errs = 0;

  function automatic ev_t mk_ev(input ev_kind_e k, input logic [31:0] d, input logic [3:0] be);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.be   = be;
    return e;
  endfunction

  // Header builder; parity bits come from per-bit coverage masks.
  function automatic logic [31:0] mk_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                         input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d    = {wc, vc, dt};
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return {2'b00, e, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic observe(input bit f, input ev_t got);
    ev_t exp;
    vecs++;
    if ((f && qf.size() == 0) || (!f && qa.size() == 0)) begin
      errs++;
      $error("FAIL unexpected_event dut%0d: observed kind %0d data %h be %h expected none",
             f, got.kind, got.data, got.be);
    end else begin
      if (f) exp = qf.pop_front();
      else   exp = qa.pop_front();
      assert (got === exp) else begin
        errs++;
        $error("FAIL event dut%0d: observed kind %0d data %h be %h expected kind %0d data %h be %h",
               f, got.kind, got.data, got.be, exp.kind, exp.data, exp.be);
      end
    end
  endtask

  task automatic sample(input bit f, input logic ov, input logic [31:0] d, input logic [3:0] be,
                        input logic fs, input logic fe, input logic ls, input logic le,
                        input logic ecc, input logic tr);
    if (ov)  observe(f, mk_ev(EvWord, d, be));
    if (fs)  observe(f, mk_ev(EvFs, '0, '0));
    if (fe)  observe(f, mk_ev(EvFe, '0, '0));
    if (ls)  observe(f, mk_ev(EvLs, '0, '0));
    if (le)  observe(f, mk_ev(EvLe, '0, '0));
    if (ecc) observe(f, mk_ev(EvEcc, '0, '0));
    if (tr)  observe(f, mk_ev(EvTrunc, '0, '0));
  endtask

  // Scoreboard monitor, sampling midway between active edges.
  always @(negedge clk_i) begin
    if (reset_i === 1'b1) begin
      sample(1'b0, bus_a.output_valid_o, bus_a.data_o, bus_a.byte_en_o, bus_a.frame_start_o,
             bus_a.frame_end_o, bus_a.line_start_o, bus_a.line_end_o, bus_a.ecc_error_o,
             bus_a.truncated_o);
      sample(1'b1, bus_f.output_valid_o, bus_f.data_o, bus_f.byte_en_o, bus_f.frame_start_o,
             bus_f.frame_end_o, bus_f.line_start_o, bus_f.line_end_o, bus_f.ecc_error_o,
             bus_f.truncated_o);
    end
  end

  task automatic push(input bit to_a, input bit to_f, input ev_t e);
    if (to_a) qa.push_back(e);
    if (to_f) qf.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus_a.data_valid_i = v;
    bus_a.data_i       = d;
    bus_f.data_valid_i = v;
    bus_f.data_i       = d;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
  endfunction

  // Header, nwords data words (payload plus any CRC/trailer), then one idle cycle.
  task automatic send_long(input logic [31:0] hdr, input int wc, input int nwords,
                           input bit to_a, input bit to_f);
    int nout;
    int emit;
    int rem;
    nout = (wc + 3) / 4;
    emit = (nwords < nout) ? nwords : nout;
    for (int i = 0; i < emit; i++) begin
      rem = wc - 4 * i;
      push(to_a, to_f, mk_ev(EvWord, word(i), (rem >= 4) ? 4'hF : 4'((1 << rem) - 1)));
    end
    if (nwords < nout) push(to_a, to_f, mk_ev(EvTrunc, '0, '0));
    drive(1'b1, hdr);
    for (int i = 0; i < nwords; i++) drive(1'b1, word(i));
    drive(1'b0, '0);
  endtask

  task automatic send_short(input logic [31:0] hdr, input ev_kind_e k, input bit to_a,
                            input bit to_f);
    push(to_a, to_f, mk_ev(k, '0, '0));
    drive(1'b1, hdr);
    drive(1'b0, '0);
  endtask

  task automatic check_fields(input string tag, input logic [2:0] ty, input logic [15:0] len,
                              input logic [1:0] vc);
    check({tag, "_type"}, bus_a.packet_type_o, ty);
    check({tag, "_len"}, bus_a.packet_length_o, len);
    check({tag, "_vc"}, bus_a.vc_o, vc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus_a.output_valid_o, 0);
    check({tag, "_data"}, bus_a.data_o, 0);
    check({tag, "_be"}, bus_a.byte_en_o, 0);
    check({tag, "_fields"}, {bus_a.packet_type_o, bus_a.packet_length_o, bus_a.vc_o}, 0);
    check({tag, "_pulses"}, {bus_a.frame_start_o, bus_a.frame_end_o, bus_a.line_start_o,
                             bus_a.line_end_o, bus_a.ecc_error_o, bus_a.truncated_o}, 0);
    check({tag, "_f_valid_len"}, {bus_f.output_valid_o, bus_f.packet_length_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0;
    bus_a.data_valid_i = 1'b0;
    bus_a.data_i       = '0;
    bus_f.data_valid_i = 1'b0;
    bus_f.data_i       = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check_zero("reset");
    reset_i = 1'b1;
    drive(1'b0, '0);

    // Frame start: pulse lands exactly one cycle after the header, for one cycle.
    push(1'b1, 1'b0, mk_ev(EvFs, '0, '0));
    drive(1'b1, 32'h0000_0000);
    check("fs_cycle", bus_a.frame_start_o, 1);
    check("fs_no_valid", bus_a.output_valid_o, 0);
    drive(1'b0, '0);
    check("fs_once", bus_a.frame_start_o, 0);

    // RAW10, WC=10: three words out (last with two bytes), trailer word dropped.
    send_long(32'h2E00_0A2B, 10, 4, 1'b1, 1'b0);
    check_fields("raw10", 3'd2, 16'd10, 2'd0);

    // Flipped header bit: ECC error, burst ignored, then a good header is accepted.
    push(1'b1, 1'b1, mk_ev(EvEcc, '0, '0));
    drive(1'b1, 32'h2E00_0A2A);
    for (int i = 0; i < 3; i++) drive(1'b1, word(i));
    drive(1'b0, '0);
    send_short(32'h0700_0001, EvFe, 1'b1, 1'b0);

    // Truncation after one payload word, then straight back to header parsing.
    send_long(32'h2E00_0A2B, 10, 1, 1'b1, 1'b0);
    send_short(32'h0B00_0002, EvLs, 1'b1, 1'b0);
    // Valid drops right after a long header.
    send_long(mk_hdr(2'd0, 6'h2B, 16'd8), 8, 0, 1'b1, 1'b0);
    send_short(32'h0C00_0003, EvLe, 1'b1, 1'b0);

    // Short DT without a sync meaning: no pulse at all.
    drive(1'b1, mk_hdr(2'd0, 6'h05, 16'd0));
    drive(1'b0, '0);
    check("short05_pulses", {bus_a.frame_start_o, bus_a.frame_end_o, bus_a.line_start_o,
                             bus_a.line_end_o}, 0);

    // Byte-count boundaries and type codes.
    send_long(mk_hdr(2'd0, 6'h2A, 16'd4), 4, 2, 1'b1, 1'b0);
    check_fields("raw8_wc4", 3'd1, 16'd4, 2'd0);
    send_long(mk_hdr(2'd0, 6'h1E, 16'd1), 1, 1, 1'b1, 1'b0);
    check_fields("yuv_wc1", 3'd5, 16'd1, 2'd0);
    send_long(mk_hdr(2'd0, 6'h2C, 16'd0), 0, 1, 1'b1, 1'b0);
    check_fields("raw12_wc0", 3'd3, 16'd0, 2'd0);
    send_long(mk_hdr(2'd0, 6'h12, 16'd3), 3, 2, 1'b1, 1'b0);
    check_fields("unsup_wc3", 3'd0, 16'd3, 2'd0);
    send_long(mk_hdr(2'd0, 6'h2D, 16'd2), 2, 1, 1'b1, 1'b0);
    check_fields("raw14_wc2", 3'd4, 16'd2, 2'd0);

    // Virtual channel filter: VC0 dropped by the filtered instance, VC1 passed.
    send_long(32'h2E00_0A2B, 10, 4, 1'b1, 1'b0);
    check("vcf_len_untouched", bus_f.packet_length_o, 16'd0);
    send_long(32'h3800_0A6B, 10, 4, 1'b1, 1'b1);
    check("vcf_vc", bus_f.vc_o, 2'd1);
    check("vcf_type_len", {bus_f.packet_type_o, bus_f.packet_length_o}, {3'd2, 16'd10});
    check_fields("vc1_unfiltered", 3'd2, 16'd10, 2'd1);

    // Reset in the middle of a WC=100 payload after five words.
    for (int i = 0; i < 5; i++) push(1'b1, 1'b0, mk_ev(EvWord, word(i), 4'hF));
    drive(1'b1, mk_hdr(2'd0, 6'h2B, 16'd100));
    for (int i = 0; i < 5; i++) drive(1'b1, word(i));
    @(negedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    check_zero("midreset");
    drive(1'b0, '0);
    drive(1'b0, '0);
    reset_i = 1'b1;
    drive(1'b0, '0);
    push(1'b1, 1'b0, mk_ev(EvFs, '0, '0));
    drive(1'b1, 32'h0000_0000);
    check("postreset_fs", bus_a.frame_start_o, 1);
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b0, '0);

    check("qa_drained", qa.size(), 0);
    check("qf_drained", qf.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
